// File: rtl/serial_rx.sv
// UART-style receiver: 2-FF synchronised rx, mid-bit sampling, 8-bit LSB-first frames.
// Define RX_PARITY_EN to expect an even-parity bit between the data bits and the stop bit.
module serial_rx #(
  parameter int F_CLK = 50_000_000,
  parameter int CNT_W = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic [2:0] baud_sel,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

`ifdef RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;
`endif

  // Bit periods rounded to the nearest clock.
  localparam logic [CNT_W-1:0] N_1200   = CNT_W'((F_CLK + 600) / 1200);
  localparam logic [CNT_W-1:0] N_2400   = CNT_W'((F_CLK + 1200) / 2400);
  localparam logic [CNT_W-1:0] N_4800   = CNT_W'((F_CLK + 2400) / 4800);
  localparam logic [CNT_W-1:0] N_9600   = CNT_W'((F_CLK + 4800) / 9600);
  localparam logic [CNT_W-1:0] N_19200  = CNT_W'((F_CLK + 9600) / 19200);
  localparam logic [CNT_W-1:0] N_38400  = CNT_W'((F_CLK + 19200) / 38400);
  localparam logic [CNT_W-1:0] N_57600  = CNT_W'((F_CLK + 28800) / 57600);
  localparam logic [CNT_W-1:0] N_115200 = CNT_W'((F_CLK + 57600) / 115200);

  state_t           state, state_nxt;
  logic             rx_meta, rx_s, rx_prev;
  logic [CNT_W-1:0] cnt, period, sel_period, half;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_reg;
  logic             fall, tick;
  logic             valid_set, ferr_set;
`ifdef RX_PARITY_EN
  logic             par_bad, perr_set;
`endif

  always_comb begin
    sel_period = N_115200;
    case (baud_sel)
      3'd0:    sel_period = N_1200;
      3'd1:    sel_period = N_2400;
      3'd2:    sel_period = N_4800;
      3'd3:    sel_period = N_9600;
      3'd4:    sel_period = N_19200;
      3'd5:    sel_period = N_38400;
      3'd6:    sel_period = N_57600;
      default: sel_period = N_115200;
    endcase
  end

  assign half = period >> 1;
  assign fall = rx_prev & ~rx_s;
  // START waits half a bit to land mid-start-bit; all later states wait a full bit.
  assign tick = (state == START) ? (cnt == half - CNT_W'(1)) : (cnt == period - CNT_W'(1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (fall) state_nxt = START;
      START:     if (tick) state_nxt = rx_s ? IDLE : DATA;
`ifdef RX_PARITY_EN
      DATA:      if (tick && bit_idx == 3'd7) state_nxt = PARITY;
      PARITY:    if (tick) state_nxt = STOP;
`else
      DATA:      if (tick && bit_idx == 3'd7) state_nxt = STOP;
`endif
      STOP:      if (tick) state_nxt = rx_s ? IDLE : WAIT_IDLE;
      WAIT_IDLE: if (rx_s) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != IDLE);
    ferr_set = (state == STOP) && tick && !rx_s;
`ifdef RX_PARITY_EN
    valid_set = (state == STOP) && tick && rx_s && !par_bad;
    perr_set  = (state == STOP) && tick && rx_s && par_bad;
`else
    valid_set = (state == STOP) && tick && rx_s;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta    <= 1'b1;
      rx_s       <= 1'b1;
      rx_prev    <= 1'b1;
      cnt        <= '0;
      period     <= '0;
      bit_idx    <= '0;
      shift_reg  <= '0;
      data       <= 8'h00;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
`ifdef RX_PARITY_EN
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      rx_meta    <= rx;
      rx_s       <= rx_meta;
      rx_prev    <= rx_s;
      data_valid <= valid_set;
      frame_err  <= ferr_set;
`ifdef RX_PARITY_EN
      parity_err <= perr_set;
`endif
      if (valid_set) data <= shift_reg;
      case (state)
        IDLE: begin
          cnt     <= '0;
          bit_idx <= '0;
`ifdef RX_PARITY_EN
          par_bad <= 1'b0;
`endif
          // Rate is frozen for the whole frame once the start edge is seen.
          if (fall) period <= sel_period;
        end
        DATA: begin
          if (tick) begin
            cnt       <= '0;
            shift_reg <= {rx_s, shift_reg[7:1]};
            bit_idx   <= bit_idx + 3'd1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
`ifdef RX_PARITY_EN
        PARITY: begin
          if (tick) begin
            cnt     <= '0;
            par_bad <= rx_s ^ (^shift_reg);
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
`endif
        WAIT_IDLE: cnt <= '0;
        default:   cnt <= tick ? '0 : cnt + CNT_W'(1);
      endcase
    end
  end

`ifndef RX_PARITY_EN
  assign parity_err = 1'b0;
`endif

endmodule
